// File: rtl/unsigned_mul_8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one row pair per cycle over four CALC cycles, with a
// per-column mask that swaps a half adder for an OR to give an approximate product.
module unsigned_mul_8x8_seq_ctrl #(
  parameter logic [27:0] MASK_RESET = 28'h0000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic        cfg_we,
  input  logic [27:0] cfg_mask,
  output logic        cfg_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state;
  logic [1:0]  cnt;
  logic [7:0]  xr, yr;
  logic [27:0] mask;
  logic [15:0] acc;

  logic [7:0]  row_a, row_b;
  logic [6:0]  pair_mask;
  logic [9:0]  sum_v, carry_v, pair_val;
  logic [15:0] term, acc_next;

  always_comb begin
    row_a = yr & {8{xr[{cnt, 1'b0}]}};
    row_b = yr & {8{xr[{cnt, 1'b1}]}};
    unique case (cnt)
      2'd0: pair_mask = mask[6:0];
      2'd1: pair_mask = mask[13:7];
      2'd2: pair_mask = mask[20:14];
      default: pair_mask = mask[27:21];
    endcase
    sum_v    = '0;
    carry_v  = '0;
    sum_v[0] = row_a[0];
    sum_v[8] = row_b[7];
    // Column j pairs a[j] with b[j-1]; a set mask bit drops the carry entirely.
    for (int j = 1; j < 8; j++) begin
      sum_v[j]     = pair_mask[j-1] ? (row_a[j] | row_b[j-1]) : (row_a[j] ^ row_b[j-1]);
      carry_v[j+1] = ~pair_mask[j-1] & row_a[j] & row_b[j-1];
    end
    pair_val = sum_v + carry_v;
    term     = {6'd0, pair_val} << {cnt, 1'b0};
    acc_next = acc + term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= 2'd0;
      acc       <= '0;
      xr        <= '0;
      yr        <= '0;
      mask      <= MASK_RESET;
      p         <= '0;
      out_valid <= 1'b0;
      cfg_ack   <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      cfg_ack <= 1'b0;
      unique case (state)
        StIdle: begin
          // A mask write and an accept in the same cycle both land; CALC sees the new mask.
          if (cfg_we) begin
            mask    <= cfg_mask;
            cfg_ack <= 1'b1;
          end
          if (in_valid) begin
            xr       <= x;
            yr       <= y;
            acc      <= '0;
            cnt      <= 2'd0;
            state    <= StCalc;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StCalc: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state     <= StDone;
            p         <= acc_next;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_mul_8x8_seq_ctrl.sv
// Directed and random checks of the sequential approximate 8x8 multiplier.
module tb_unsigned_mul_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        cfg_we = 1'b0;
  logic [27:0] cfg_mask = '0;
  logic        cfg_ack;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] p;
  logic        busy;

  int checks = 0;
  int failures = 0;

  unsigned_mul_8x8_seq_ctrl #(.MASK_RESET(28'h0000000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_ack(cfg_ack), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum the weighted bits each column produces.
  function automatic logic [15:0] model(input logic [7:0] xi, input logic [7:0] yi,
                                        input logic [27:0] m);
    int total = 0;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a, b;
      int pk;
      a  = yi & {8{xi[2*k]}};
      b  = yi & {8{xi[2*k+1]}};
      pk = int'(a[0]);
      for (int j = 1; j < 8; j++) begin
        if (m[7*k+j-1]) pk += int'(a[j] | b[j-1]) * (1 << j);
        else            pk += (int'(a[j]) + int'(b[j-1])) * (1 << j);
      end
      pk += int'(b[7]) * 256;
      total += pk * (1 << (2*k));
    end
    return total[15:0];
  endfunction

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_timeout: got %b want 1", out_valid);
    end
  endtask

  task automatic run_op(input logic [7:0] xi, input logic [7:0] yi, input logic with_cfg,
                        input logic [27:0] mi, output logic [15:0] pr, output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    in_valid = 1'b1; x = xi; y = yi; cfg_we = with_cfg; cfg_mask = mi;
    step();
    in_valid = 1'b0; cfg_we = 1'b0;
    x = 8'($urandom); y = 8'($urandom);
    wait_out(lat);
    pr = p;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic cfg_write(input logic [27:0] mi);
    cfg_we = 1'b1; cfg_mask = mi;
    step();
    cfg_we = 1'b0;
    checks++;
    if (cfg_ack !== 1'b1) begin
      failures++;
      $display("FAIL cfg_ack_pulse: got %b want 1", cfg_ack);
    end
    step();
    checks++;
    if (cfg_ack !== 1'b0) begin
      failures++;
      $display("FAIL cfg_ack_single: got %b want 0", cfg_ack);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({p, out_valid, cfg_ack, busy} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: p=%h ov=%b ack=%b busy=%b want all 0",
               p, out_valid, cfg_ack, busy);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_exact_ff();
    int lat = 1;
    in_valid = 1'b1; x = 8'hFF; y = 8'hFF;
    step();
    in_valid = 1'b0;
    while (lat <= 5) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ff_in_ready_low: cycle N+%0d got %b want 0", lat, in_ready);
      end
      if (out_valid) break;
      step();
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL ff_latency: got %0d want 5", lat);
    end
    checks++;
    if (p !== 16'hFE01) begin
      failures++;
      $display("FAIL ff_product: got %h want fe01", p);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_approx();
    logic [15:0] r;
    int lat;
    cfg_write(28'hFFFFFFF);
    run_op(8'd3, 8'd3, 1'b0, '0, r, lat);
    checks++;
    if (r !== 16'd7) begin
      failures++;
      $display("FAIL approx_3x3: got %h want 0007", r);
    end
    run_op(8'd1, 8'hFF, 1'b0, '0, r, lat);
    checks++;
    if (r !== 16'h00FF) begin
      failures++;
      $display("FAIL approx_1xff: got %h want 00ff", r);
    end
    cfg_write(28'h0);
  endtask

  task automatic test_zero();
    logic [15:0] r;
    int lat;
    run_op(8'd0, 8'h55, 1'b0, '0, r, lat);
    checks++;
    if (r !== 16'd0 || lat !== 5) begin
      failures++;
      $display("FAIL zero_x: got p=%h lat=%0d want 0000 lat 5", r, lat);
    end
    run_op(8'h80, 8'd0, 1'b0, '0, r, lat);
    checks++;
    if (r !== 16'd0 || lat !== 5) begin
      failures++;
      $display("FAIL zero_y: got p=%h lat=%0d want 0000 lat 5", r, lat);
    end
  endtask

  task automatic test_stall();
    int lat;
    in_valid = 1'b1; x = 8'h12; y = 8'h34;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, p, in_ready, busy} !== {1'b1, 16'h03A8, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL stall_hold: cyc %0d ov=%b p=%h ir=%b busy=%b want 1 03a8 0 1",
                 i, out_valid, p, in_ready, busy);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_cfg();
    logic [15:0] r;
    int lat;
    in_valid = 1'b1; x = 8'd3; y = 8'd3;
    step();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_mask = 28'hFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cfg_ack !== 1'b0) begin
        failures++;
        $display("FAIL cfg_busy_ack: got %b want 0", cfg_ack);
      end
    end
    cfg_we = 1'b0;
    wait_out(lat);
    checks++;
    if (p !== 16'd9) begin
      failures++;
      $display("FAIL cfg_busy_product: got %h want 0009", p);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run_op(8'd3, 8'd3, 1'b0, '0, r, lat);
    checks++;
    if (r !== 16'd9) begin
      failures++;
      $display("FAIL cfg_mask_kept: got %h want 0009", r);
    end
    in_valid = 1'b1; x = 8'd3; y = 8'd3; cfg_we = 1'b1; cfg_mask = 28'hFFFFFFF;
    step();
    in_valid = 1'b0; cfg_we = 1'b0;
    checks++;
    if (cfg_ack !== 1'b1) begin
      failures++;
      $display("FAIL cfg_same_cycle_ack: got %b want 1", cfg_ack);
    end
    wait_out(lat);
    checks++;
    if (p !== 16'd7) begin
      failures++;
      $display("FAIL cfg_same_cycle_mask: got %h want 0007", p);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    cfg_write(28'h0);
  endtask

  task automatic test_reset_calc();
    logic [15:0] r;
    int lat;
    logic seen_valid = 1'b0;
    in_valid = 1'b1; x = 8'hFF; y = 8'hFF;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({busy, out_valid, p} !== 18'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_calc_state: busy=%b ov=%b p=%h ir=%b want 0 0 0000 1",
               busy, out_valid, p, in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_calc_no_out: got %b want 0", seen_valid);
    end
    run_op(8'h10, 8'h0A, 1'b0, '0, r, lat);
    checks++;
    if (r !== 16'h00A0 || lat !== 5) begin
      failures++;
      $display("FAIL reset_calc_next_op: got p=%h lat=%0d want 00a0 lat 5", r, lat);
    end
  endtask

  task automatic test_random();
    logic [27:0] m = '0;
    logic [15:0] r;
    logic [7:0] xi, yi;
    int lat;
    for (int i = 0; i < 4000; i++) begin
      if (i % 16 == 0) begin
        m = ((i / 16) % 4 == 0) ? 28'h0 : 28'($urandom);
        cfg_write(m);
      end
      xi = 8'($urandom);
      yi = 8'($urandom);
      run_op(xi, yi, 1'b0, '0, r, lat);
      checks++;
      if (r !== model(xi, yi, m)) begin
        failures++;
        $display("FAIL random_model: x=%h y=%h m=%h got %h want %h",
                 xi, yi, m, r, model(xi, yi, m));
      end
      if (m == 28'h0) begin
        checks++;
        if (r !== 16'(xi * yi)) begin
          failures++;
          $display("FAIL random_exact: x=%h y=%h got %h want %h", xi, yi, r, 16'(xi * yi));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_ff();
    test_approx();
    test_zero();
    test_stall();
    test_cfg();
    test_reset_calc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
